// File: rtl/lut_layer_sequencer_pkg.sv
// Shared types and width helpers for the LUT layer sequencer.
// Holds the FSM state enum and functions that derive table and index widths.
// No ports. Imported by the interface, the neuron store and the top level.
package lut_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } lut_seq_state_t;

   localparam int DEF_NEURONS  = 16;
   localparam int DEF_IN_WIDTH = 32;
   localparam int DEF_FANIN    = 6;

   // Truth-table width for a given fan-in (one bit per lookup address).
   function automatic int tbl_width(input int fanin);
      return 1 << fanin;
   endfunction

   // Width of one connection index into the input vector.
   function automatic int idx_width(input int in_width);
      return (in_width > 1) ? $clog2(in_width) : 1;
   endfunction

endpackage

// File: rtl/lut_layer_sequencer_if.sv
// Bundles the data, result and configuration handshakes of the LUT layer sequencer.
// master: upstream source / downstream sink / host loader side; slave: the sequencer.
// Signals: in_* (vector in), out_* (result out), cfg_* (per-neuron table/connection load).
interface lut_layer_sequencer_if
   import lut_seq_pkg::*;
#(
   parameter int NEURONS  = DEF_NEURONS,
   parameter int IN_WIDTH = DEF_IN_WIDTH,
   parameter int FANIN    = DEF_FANIN,
   parameter int IDX_W    = idx_width(IN_WIDTH)
);
   localparam int TBL_W = tbl_width(FANIN);
   localparam int NW    = $clog2(NEURONS);

   logic                   in_valid;
   logic                   in_ready;
   logic [IN_WIDTH-1:0]    in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [NEURONS-1:0]     out_data;
   logic                   cfg_we;
   logic [NW-1:0]          cfg_neuron;
   logic [TBL_W-1:0]       cfg_table;
   logic [FANIN*IDX_W-1:0] cfg_conn;
   logic                   cfg_busy;

   modport master (
      output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_table, cfg_conn,
      input  in_ready, out_valid, out_data, cfg_busy
   );

   modport slave (
      input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_table, cfg_conn,
      output in_ready, out_valid, out_data, cfg_busy
   );

endinterface

// File: rtl/lut_layer_sequencer_neuron_store.sv
// Per-neuron truth tables and fan-in connection indices, plus the address-gather mux.
// Writes land at the clock edge; both read paths (gather, table bit) are combinational.
// Ports: clk/rst, wr_* (config write), gath_n_i/vec_i -> addr_o, tbl_n_i/tbl_addr_i -> bit_o.
module lut_seq_neuron_store
   import lut_seq_pkg::*;
#(
   parameter int NEURONS  = DEF_NEURONS,
   parameter int IN_WIDTH = DEF_IN_WIDTH,
   parameter int FANIN    = DEF_FANIN,
   parameter int IDX_W    = idx_width(IN_WIDTH),
   localparam int TBL_W   = tbl_width(FANIN),
   localparam int NW      = $clog2(NEURONS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en_i,
   input  logic [NW-1:0]          wr_n_i,
   input  logic [TBL_W-1:0]       wr_tbl_i,
   input  logic [FANIN*IDX_W-1:0] wr_conn_i,
   input  logic [NW-1:0]          gath_n_i,
   input  logic [IN_WIDTH-1:0]    vec_i,
   output logic [FANIN-1:0]       addr_o,
   input  logic [NW-1:0]          tbl_n_i,
   input  logic [FANIN-1:0]       tbl_addr_i,
   output logic                   bit_o
);

   logic [TBL_W-1:0]       tbl_q  [NEURONS];
   logic [FANIN*IDX_W-1:0] conn_q [NEURONS];

   // Targets beyond the last neuron are dropped rather than aliased.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NEURONS; n++) begin
            tbl_q[n]  <= '0;
            conn_q[n] <= '0;
         end
      end else if (wr_en_i && (int'(wr_n_i) < NEURONS)) begin
         tbl_q[wr_n_i]  <= wr_tbl_i;
         conn_q[wr_n_i] <= wr_conn_i;
      end
   end

   // Address bit k comes from the input bit named by connection field k;
   // indices past the end of the vector read as 0.
   always_comb begin
      logic [IDX_W-1:0] idx;
      addr_o = '0;
      idx    = '0;
      for (int k = 0; k < FANIN; k++) begin
         idx       = conn_q[gath_n_i][k*IDX_W +: IDX_W];
         addr_o[k] = (int'(idx) < IN_WIDTH) ? vec_i[idx] : 1'b0;
      end
   end

   assign bit_o = tbl_q[tbl_n_i][tbl_addr_i];

endmodule

// File: rtl/lut_layer_sequencer.sv
// One LogicNets layer evaluated by a single shared LUT engine, one neuron per cycle.
// Latency: accept in cycle t -> out_valid at t+1+NEURONS (t+2+NEURONS with LUT_SEQ_REG_LOOKUP_EN).
// Backpressure: no new vector is accepted until the result handshake completes; config is IDLE-only.
// Ports: clk, rst (sync, active-high), bus (slave modport: in_*, out_*, cfg_*).
// Build option LUT_SEQ_REG_LOOKUP_EN registers the gathered address before the table read.
module lut_layer_sequencer
   import lut_seq_pkg::*;
#(
   parameter int NEURONS  = DEF_NEURONS,
   parameter int IN_WIDTH = DEF_IN_WIDTH,
   parameter int FANIN    = DEF_FANIN,
   parameter int IDX_W    = idx_width(IN_WIDTH)
) (
   input logic                  clk,
   input logic                  rst,
   lut_layer_sequencer_if.slave bus
);

   localparam int NW    = $clog2(NEURONS);
   localparam int CNT_W = $clog2(NEURONS + 1);

   lut_seq_state_t      state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [IN_WIDTH-1:0] vec_q;
   logic [NEURONS-1:0]  out_q;
   logic                out_valid_q;
   logic                idle_q;

   logic [FANIN-1:0]    gath_addr;
   logic [FANIN-1:0]    tbl_addr;
   logic [NW-1:0]       tbl_n;
   logic                lut_bit;
   logic                wr_en;
   logic                eval_last;

`ifdef LUT_SEQ_REG_LOOKUP_EN
   // The table read trails address formation by one cycle, so the neuron
   // being written is cnt-1 and the first EVAL cycle only fills the stage.
   logic [FANIN-1:0] addr_q;

   always_ff @(posedge clk) begin
      if (rst) addr_q <= '0;
      else     addr_q <= gath_addr;
   end

   assign tbl_addr  = addr_q;
   assign tbl_n     = NW'(cnt_q - 1'b1);
   assign wr_en     = (cnt_q != '0);
   assign eval_last = (cnt_q == CNT_W'(NEURONS));
`else
   assign tbl_addr  = gath_addr;
   assign tbl_n     = cnt_q[NW-1:0];
   assign wr_en     = 1'b1;
   assign eval_last = (cnt_q == CNT_W'(NEURONS - 1));
`endif

   lut_seq_neuron_store #(
      .NEURONS  (NEURONS),
      .IN_WIDTH (IN_WIDTH),
      .FANIN    (FANIN),
      .IDX_W    (IDX_W)
   ) u_store (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (bus.cfg_we & idle_q),
      .wr_n_i     (bus.cfg_neuron),
      .wr_tbl_i   (bus.cfg_table),
      .wr_conn_i  (bus.cfg_conn),
      .gath_n_i   (cnt_q[NW-1:0]),
      .vec_i      (vec_q),
      .addr_o     (gath_addr),
      .tbl_n_i    (tbl_n),
      .tbl_addr_i (tbl_addr),
      .bit_o      (lut_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         vec_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         idle_q      <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  vec_q   <= bus.in_data;
                  cnt_q   <= '0;
                  idle_q  <= 1'b0;
                  state_q <= EVAL;
               end
            end
            EVAL: begin
               if (wr_en) out_q[tbl_n] <= lut_bit;
               cnt_q <= cnt_q + 1'b1;
               if (eval_last) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  idle_q      <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Masking with rst keeps in_ready low for the whole reset cycle.
   assign bus.in_ready  = idle_q & ~rst;
   assign bus.cfg_busy  = ~idle_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_q;

endmodule
